ram8_sweep: RTL
===============

// Module: ram8_sweep
// PURPOSE
//   8-word x WIDTH register memory. Sits directly downstream of the 1-to-2 load
//   demultiplexer stage: the load strobe is routed to exactly one word through a
//   3-level demux tree driven by address. Adds a clear sequencer that zeroes all
//   8 words, one per cycle, and flags busy meanwhile. Leaf RAM for the RAM64 tree.
// PARAMETERS
//   WIDTH     16   data width of each word, in bits
// PORTS
//   clk       in   1      single clock; all state updates on its rising edge
//   reset     in   1      synchronous, active-high reset
//   in        in   WIDTH  write data
//   address   in   3      word select for both read and write
//   load      in   1      write strobe; mem[address] <= in at the next edge
//   clear     in   1      request a zeroing sweep of all 8 words
//   out       out  WIDTH  mem[address], combinational read
//   busy      out  1      1 while the sweep is in progress
// BEHAVIOUR
//   Reset (sampled at posedge, reset=1)
//     - All 8 words <= 0; state <= IDLE; sweep counter <= 0.
//     - Has priority over load and clear in the same cycle.
//     - Reset during SWEEP aborts the sweep immediately, with the same result.
//     - After reset: busy = 0; out = 0 for every address.
//   Read
//     - out = mem[address], purely combinational, zero latency.
//     - A write becomes visible on out the cycle after the edge; no bypass.
//     - Reads are legal in every state, including SWEEP.
//   Load demux
//     - load is decoded to 8 one-hot word enables by a binary demux tree:
//       address[2], then address[1], then address[0].
//     - Exactly one word enable may be high; the other 7 words hold.
//   State machine: IDLE, SWEEP (2 states, counter cnt[2:0])
//     - IDLE, clear=1: -> SWEEP, cnt <= 0. load that cycle is dropped
//       (clear has priority).
//     - IDLE, clear=0, load=1: mem[address] <= in.
//     - SWEEP, each cycle: mem[cnt] <= 0, cnt <= cnt + 1.
//     - SWEEP, cnt == 7: write word 7, -> IDLE, cnt <= 0.
//     - SWEEP lasts exactly 8 cycles; busy = (state == SWEEP), a registered state
//       decode.
//     - During SWEEP, load and clear are ignored: no write, no restart, nothing
//       queued.
//   Boundary rules
//     - address is 3 bits, so there is no out-of-range access.
//     - cnt wraps 7 -> 0 only on the SWEEP -> IDLE transition.
//     - clear held high across the SWEEP -> IDLE edge starts a new sweep on the
//       first IDLE cycle.
//     - load with in = all-ones writes all-ones; no data masking.
// TESTING
//   1. Reset, then read address 0..7 -> out = 0 each; busy = 0.
//   2. load=1, address=5, in=16'hBEEF, 1 cycle -> next cycle out(addr 5)=BEEF;
//      addr 4 and 6 read 0.
//   3. Write 16'h1111*k to word k (k=1..7), then read all
//      -> each word holds its own value; no aliasing.
//   4. Fill all words, pulse clear -> busy = 1 for exactly 8 cycles; word k reads
//      0 from cycle k+1 of the sweep; busy = 0 afterwards, all words 0.
//   5. load=1, in=16'h00FF, address=2 during SWEEP cycle 4
//      -> ignored; word 2 is 0 after the sweep.
//   6. Same cycle load=1 and clear=1 in IDLE -> load dropped, sweep starts.
//      reset=1 at sweep cycle 3 -> next cycle busy = 0, all words 0.

Source files
------------

// File: rtl/ram8_sweep.sv
// Eight-word register memory with a one-hot load demux tree and a clear sequencer
// that zeroes every word, one per cycle, while busy_o is high.
module ram8_sweep #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  input  logic [2:0]       address_i,
  input  logic             load_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] mem_q [8];

  logic       load_d;
  logic [1:0] en_l1_d;
  logic [3:0] en_l2_d;
  logic [7:0] word_en_d;

  // A pending clear or an active sweep swallows the load strobe.
  assign load_d = load_i && (state_q == IDLE) && !clear_i;

  always_comb begin
    en_l1_d   = '0;
    en_l2_d   = '0;
    word_en_d = '0;
    en_l1_d[0] = load_d & ~address_i[2];
    en_l1_d[1] = load_d &  address_i[2];
    for (int i = 0; i < 2; i++) begin
      en_l2_d[2*i]   = en_l1_d[i] & ~address_i[1];
      en_l2_d[2*i+1] = en_l1_d[i] &  address_i[1];
    end
    for (int i = 0; i < 4; i++) begin
      word_en_d[2*i]   = en_l2_d[i] & ~address_i[0];
      word_en_d[2*i+1] = en_l2_d[i] &  address_i[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int k = 0; k < 8; k++) mem_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          for (int k = 0; k < 8; k++) begin
            if (word_en_d[k]) mem_q[k] <= in_i;
          end
        end
        SWEEP: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == 3'd7) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_o  = mem_q[address_i];
  assign busy_o = busy_q;

endmodule
